pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined MIPS core. It generates the write-enable and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, covering three cases:
- load-use hazards;
- taken branches resolved in MEM;
- multi-cycle data-memory accesses, supervised by a timeout.
It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared state encoding and pipeline control-bundle layout
package pipe_ctrl_pkg;

  // Hazard sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // Bit positions of the control bundle carried in IF/ID, ID/EX, EX/MEM and MEM/WB.
  // A flush or bubble clears the whole bundle, which turns the slot into a NOP.
  localparam int CTL_REGWRITE = 0;
  localparam int CTL_MEMTOREG = 1;
  localparam int CTL_MEMREAD  = 2;
  localparam int CTL_MEMWRITE = 3;
  localparam int CTL_BRANCH   = 4;
  localparam int CTL_ALUSRC   = 5;
  localparam int CTL_REGDST   = 6;
  localparam int CTL_W        = 7;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and stage-register controls between pipeline and sequencer
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);

  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ready_i;

  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_flush_o;
  logic             exmem_write_o;
  logic             exmem_flush_o;
  logic             memwb_bubble_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Pipeline datapath side: reports hazards, obeys the controls
  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
    output branch_taken_i, dmem_req_i, dmem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
    input  exmem_write_o, exmem_flush_o, memwb_bubble_o, err_o, stall_cnt_o, flush_cnt_o
  );

  // Hazard sequencer side
  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
    input  branch_taken_i, dmem_req_i, dmem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
    output exmem_write_o, exmem_flush_o, memwb_bubble_o, err_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter for performance debug
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // Count up on inc_i, sticking at all-ones instead of wrapping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for load-use, taken-branch and data-memory wait hazards
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_L = 8'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wcnt;
  logic [7:0]       w_wcnt_nxt;
  logic             r_err;
  logic             w_err_set;
  logic             w_load_use;
  logic             w_freeze;
  logic             w_rules;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_write;
  logic             w_idex_flush;
  logic             w_exmem_write;
  logic             w_exmem_flush;
  logic             w_memwb_bubble;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  // State, wait counter and sticky timeout error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_wcnt  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next state plus Mealy stage controls; a frozen pipe ignores branch and load-use
  // because EX/MEM and ID/EX hold still and present the same hazard again later
  always_comb begin
    w_load_use = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                 ((bus.idex_rt_i == bus.ifid_rs_i) ||
                  (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));

    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_err_set   = 1'b0;
    w_freeze    = 1'b0;
    w_rules     = 1'b0;

    case (r_state)
      RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ready_i) begin
          w_freeze    = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_wcnt_nxt  = 8'd1;
        end else begin
          w_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready_i) begin
          w_freeze = 1'b1;
          if (r_wcnt < TIMEOUT_L) begin
            w_wcnt_nxt = r_wcnt + 8'd1;
          end else begin
            w_state_nxt = ERROR;
            w_err_set   = 1'b1;
          end
        end else begin
          w_rules     = 1'b1;
          w_state_nxt = RUN;
          w_wcnt_nxt  = 8'd0;
        end
      end
      ERROR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wcnt_nxt  = 8'd0;
      end
    endcase

    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_write   = 1'b1;
    w_idex_flush   = 1'b0;
    w_exmem_write  = 1'b1;
    w_exmem_flush  = 1'b0;
    w_memwb_bubble = 1'b0;
    w_flush_inc    = 1'b0;

    if (rst_i) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_write   = 1'b0;
      w_exmem_write  = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_flush   = 1'b1;
      w_exmem_flush  = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (w_freeze) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_write   = 1'b0;
      w_exmem_write  = 1'b0;
      w_memwb_bubble = 1'b1;
    end else if (w_rules && bus.branch_taken_i) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      w_flush_inc   = 1'b1;
    end else if (w_rules && w_load_use) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_flush = 1'b1;
    end

    w_stall_inc = !rst_i && !w_pc_write;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flush_inc),
    .cnt_o (w_flush_cnt)
  );

  assign bus.pc_write_o     = w_pc_write;
  assign bus.ifid_write_o   = w_ifid_write;
  assign bus.ifid_flush_o   = w_ifid_flush;
  assign bus.idex_write_o   = w_idex_write;
  assign bus.idex_flush_o   = w_idex_flush;
  assign bus.exmem_write_o  = w_exmem_write;
  assign bus.exmem_flush_o  = w_exmem_flush;
  assign bus.memwb_bubble_o = w_memwb_bubble;
  assign bus.err_o          = r_err;
  assign bus.stall_cnt_o    = w_stall_cnt;
  assign bus.flush_cnt_o    = w_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for the pipeline hazard sequencer
module tb_pipe_hazard_ctrl;

  // Packed output order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_bubble
  localparam logic [7:0] O_DEF = 8'b1101_0100;
  localparam logic [7:0] O_LU  = 8'b0001_1100;
  localparam logic [7:0] O_BR  = 8'b1111_1110;
  localparam logic [7:0] O_FRZ = 8'b0000_0001;
  localparam logic [7:0] O_RST = 8'b0010_1011;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] id_rt;
    logic       uses;
    logic       br;
    logic       req;
    logic       rdy;
    logic [7:0] exp_out;
    logic [3:0] exp_stall;
    logic [3:0] exp_flush;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] outs();
    return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_write_o,
            bus.idex_flush_o, bus.exmem_write_o, bus.exmem_flush_o, bus.memwb_bubble_o};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                        input logic [4:0] id_rt, input logic uses, input logic br,
                        input logic req, input logic rdy);
    bus.idex_memread_i = mr;
    bus.idex_rt_i      = ex_rt;
    bus.ifid_rs_i      = rs;
    bus.ifid_rt_i      = id_rt;
    bus.ifid_uses_rt_i = uses;
    bus.branch_taken_i = br;
    bus.dmem_req_i     = req;
    bus.dmem_ready_i   = rdy;
  endtask

  // Drive inputs at negedge, check combinational outputs before the posedge
  task automatic step(input string nm, input logic mr, input logic [4:0] ex_rt,
                      input logic [4:0] rs, input logic [4:0] id_rt, input logic uses,
                      input logic br, input logic req, input logic rdy, input logic [7:0] exp);
    @(negedge clk);
    set_in(mr, ex_rt, rs, id_rt, uses, br, req, rdy);
    #1;
    chk(nm, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_outs", outs(), O_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_err", {7'd0, bus.err_o}, 8'd0);
    chk("reset_stall", {4'd0, bus.stall_cnt_o}, 8'd0);
    chk("reset_flush", {4'd0, bus.flush_cnt_o}, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    //          mr ex_rt rs id_rt uses br req rdy  out    stall flush
    vecs[0] = '{1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, O_LU,  4'd1, 4'd0};
    vecs[1] = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF, 4'd1, 4'd0};
    vecs[2] = '{1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF, 4'd1, 4'd0};
    vecs[3] = '{1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, O_DEF, 4'd1, 4'd0};
    vecs[4] = '{1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0, O_LU,  4'd2, 4'd0};
    vecs[5] = '{1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0, O_BR,  4'd2, 4'd1};
    vecs[6] = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_DEF, 4'd2, 4'd1};
    vecs[7] = '{1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 1, O_LU,  4'd3, 4'd1};
    vecs[8] = '{0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, O_DEF, 4'd3, 4'd1};
    vecs[9] = '{0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_BR,  4'd3, 4'd2};

    do_reset();

    // Single-cycle RUN-state vectors with running counter expectations
    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d_outs", i), vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].id_rt,
           vecs[i].uses, vecs[i].br, vecs[i].req, vecs[i].rdy, vecs[i].exp_out);
      chk($sformatf("vec%0d_stall", i), {4'd0, bus.stall_cnt_o}, {4'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_flush", i), {4'd0, bus.flush_cnt_o}, {4'd0, vecs[i].exp_flush});
    end

    // Memory wait: three frozen cycles (branch ignored while frozen), release applies branch
    do_reset();
    step("mw_c1", 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ);
    step("mw_c2", 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ);
    step("mw_c3", 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ);
    chk("mw_flush_frozen", {4'd0, bus.flush_cnt_o}, 8'd0);
    step("mw_release", 0, 0, 0, 0, 0, 1, 1, 1, O_BR);
    chk("mw_stall", {4'd0, bus.stall_cnt_o}, 8'd3);
    chk("mw_flush", {4'd0, bus.flush_cnt_o}, 8'd1);
    chk("mw_err", {7'd0, bus.err_o}, 8'd0);
    step("mw_after", 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);

    // Timeout: ready never rises, error after the fifth stall cycle
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      step($sformatf("to_c%0d", c), 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ);
      chk($sformatf("to_err_c%0d", c), {7'd0, bus.err_o}, (c == 5) ? 8'd1 : 8'd0);
    end
    step("to_err_frozen", 1, 5'd8, 5'd8, 0, 0, 1, 1, 1, O_FRZ);
    chk("to_err_sticky", {7'd0, bus.err_o}, 8'd1);
    chk("to_stall", {4'd0, bus.stall_cnt_o}, 8'd6);
    chk("to_flush", {4'd0, bus.flush_cnt_o}, 8'd0);
    do_reset();
    step("to_run_again", 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
    chk("to_run_err", {7'd0, bus.err_o}, 8'd0);

    // Saturation: 20 load-use stalls on a 4-bit counter
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step($sformatf("sat_c%0d", c), 1, 5'd8, 5'd8, 0, 0, 0, 0, 0, O_LU);
      if (c == 14 || c == 15 || c == 20) begin
        chk($sformatf("sat_cnt_c%0d", c), {4'd0, bus.stall_cnt_o}, (c == 14) ? 8'd14 : 8'd15);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
